aes_dec_cbc_unloader: RTL and testbench

AES_DEC_CBC_UNLOADER -- requirements
Module: aes_dec_cbc_unloader

---
 rtl/aes_dec_cbc_unloader_pkg.sv | 32 +++
 rtl/aes_dec_cbc_unloader.sv | 149 ++++++++++++++
 tb/tb_aes_dec_cbc_unloader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_cbc_unloader_pkg.sv
// Shared types and constants for the AES decrypt CBC unloader.
package aes_dec_cbc_unloader_pkg;

  localparam int BLK_W         = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;
  localparam int CNT_W         = 16;
  localparam int IDX_W         = 2;

  // Index of the final word in a block; the word index wraps only after this one.
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_BLK - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Select one 32-bit word of a block, most-significant word first.
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLK_W-1:0] blk,
                                                 input logic [IDX_W-1:0] idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      2'd3:    w = blk[31:0];
      default: w = blk[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_dec_cbc_unloader.sv
// Post-processes AES decrypt core output: applies the CBC chaining XOR
// (or passes through in ECB mode) and serialises each 128-bit block into
// four 32-bit words with a valid/ready handshake.
module aes_dec_cbc_unloader
  import aes_dec_cbc_unloader_pkg::*;
#(
  parameter int CBC_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iv_load,
  input  logic [BLK_W-1:0]    iv,
  input  logic                blk_valid,
  output logic                blk_ready,
  input  logic [BLK_W-1:0]    blk_pt,
  input  logic [BLK_W-1:0]    blk_ct,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_word,
  output logic                out_last,
  output logic [CNT_W-1:0]    blk_count
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLK_W-1:0]   blk_buf_q, blk_buf_d;
  logic [BLK_W-1:0]   chain_q, chain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [WORD_W-1:0]  out_word_q, out_word_d;

  logic               blk_ready_s;
  logic               accept_s;
  logic               word_hs_s;
  logic [BLK_W-1:0]   chain_eff_s;

  // Handshake decode: a new block can enter while idle, or as the last word leaves.
  always_comb begin
    blk_ready_s = (state_q == ST_IDLE) ||
                  ((state_q == ST_SEND) && (idx_q == IDX_LAST) && out_ready);
    accept_s    = blk_valid && blk_ready_s;
    word_hs_s   = (state_q == ST_SEND) && out_ready;
    // An IV loaded in the same idle cycle as an accept chains this very block.
    if ((state_q == ST_IDLE) && iv_load) begin
      chain_eff_s = iv;
    end else begin
      chain_eff_s = chain_q;
    end
  end

  // Next-state logic: leave SEND only when the last word goes without a refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (word_hs_s && (idx_q == IDX_LAST) && !accept_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: block buffer, chaining register, word index, block counter.
  always_comb begin
    blk_buf_d = blk_buf_q;
    chain_d   = chain_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    if (accept_s) begin
      if (CBC_EN != 0) begin
        blk_buf_d = blk_pt ^ chain_eff_s;
      end else begin
        blk_buf_d = blk_pt;
      end
      chain_d = blk_ct;
      idx_d   = 2'd0;
    end else if ((state_q == ST_IDLE) && iv_load) begin
      chain_d = iv;
    end else if (word_hs_s && (idx_q != IDX_LAST)) begin
      idx_d = idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end
    if (word_hs_s && (idx_q == IDX_LAST)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output logic: outputs are registered, computed from the next state and index.
  always_comb begin
    out_valid_d = (state_d == ST_SEND);
    out_last_d  = (state_d == ST_SEND) && (idx_d == IDX_LAST);
    if (state_d == ST_SEND) begin
      out_word_d = word_sel(blk_buf_d, idx_d);
    end else begin
      out_word_d = out_word_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset discards any partially sent block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= 2'd0;
      blk_buf_q   <= 128'd0;
      chain_q     <= 128'd0;
      cnt_q       <= 16'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_word_q  <= 32'd0;
    end else begin
      idx_q       <= idx_d;
      blk_buf_q   <= blk_buf_d;
      chain_q     <= chain_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_word_q  <= out_word_d;
    end
  end

  assign blk_ready = blk_ready_s;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_word  = out_word_q;
  assign blk_count = cnt_q;

endmodule

// File: tb/tb_aes_dec_cbc_unloader.sv
// Directed bench for aes_dec_cbc_unloader: a CBC instance and an ECB
// instance share all inputs; vectors come from SP 800-38A F.2.2.
module tb_aes_dec_cbc_unloader;

  logic         clk;
  logic         rst_n;
  logic         iv_load;
  logic [127:0] iv;
  logic         blk_valid;
  logic [127:0] blk_pt;
  logic [127:0] blk_ct;
  logic         out_ready;

  logic         blk_ready,   blk_ready_e;
  logic         out_valid,   out_valid_e;
  logic [31:0]  out_word,    out_word_e;
  logic         out_last,    out_last_e;
  logic [15:0]  blk_count,   blk_count_e;

  int nchk;
  int nfail;
  int exp_cnt;

  localparam logic [127:0] IV0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] CT1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] EXP1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2  = 128'hd86421fb9f1a1eda505ee1375746972c;
  localparam logic [127:0] CT2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] EXP2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  aes_dec_cbc_unloader #(.CBC_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .iv_load(iv_load), .iv(iv),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_pt(blk_pt), .blk_ct(blk_ct),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_last(out_last), .blk_count(blk_count)
  );

  aes_dec_cbc_unloader #(.CBC_EN(0)) dut_ecb (
    .clk(clk), .rst_n(rst_n), .iv_load(iv_load), .iv(iv),
    .blk_valid(blk_valid), .blk_ready(blk_ready_e), .blk_pt(blk_pt), .blk_ct(blk_ct),
    .out_valid(out_valid_e), .out_ready(out_ready), .out_word(out_word_e),
    .out_last(out_last_e), .blk_count(blk_count_e)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0]   iv_mode;   // 0 none, 1 load in a prior idle cycle, 2 load with the accept
    logic [127:0] iv_val;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a block and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [1:0] mode, input logic [127:0] v_iv,
                      input logic [127:0] v_pt, input logic [127:0] v_ct);
    int n;
    @(negedge clk);
    if (mode == 2'd1) begin
      iv_load = 1'b1;
      iv      = v_iv;
      @(negedge clk);
      iv_load = 1'b0;
    end
    blk_valid = 1'b1;
    blk_pt    = v_pt;
    blk_ct    = v_ct;
    iv_load   = (mode == 2'd2);
    iv        = v_iv;
    n = 0;
    while (!blk_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!blk_ready) begin
      nchk++;
      nfail++;
      $display("FAIL send_timeout: blk_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    iv_load   = 1'b0;
  endtask

  // Collect four words with out_ready held high, one per cycle.
  task automatic collect(input logic [127:0] exp_m, input logic [127:0] exp_e,
                         input bit do_m, input string name);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      chk($sformatf("%s valid w%0d", name, w), 32'(out_valid), 32'd1);
      chk($sformatf("%s last w%0d", name, w), 32'(out_last), (w == 3) ? 32'd1 : 32'd0);
      if (do_m) begin
        chk($sformatf("%s word w%0d", name, w), out_word, exp_m[127-32*w -: 32]);
      end
      chk($sformatf("%s ecb word w%0d", name, w), out_word_e, exp_e[127-32*w -: 32]);
      chk($sformatf("%s ecb last w%0d", name, w), 32'(out_last_e), (w == 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    nchk      = 0;
    nfail     = 0;
    exp_cnt   = 0;
    rst_n     = 1'b0;
    iv_load   = 1'b0;
    iv        = 128'd0;
    blk_valid = 1'b0;
    blk_pt    = 128'd0;
    blk_ct    = 128'd0;
    out_ready = 1'b1;

    vecs[0] = '{2'd1, IV0, PT1, CT1, EXP1};
    vecs[1] = '{2'd0, 128'd0, PT2, CT2, EXP2};
    vecs[2] = '{2'd2, 128'd0, 128'h11111111222222223333333344444444,
                128'hdeadbeef0123456789abcdeff0f0f0f0, 128'h11111111222222223333333344444444};
    vecs[3] = '{2'd0, 128'd0, 128'd0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
                128'hdeadbeef0123456789abcdeff0f0f0f0};
    vecs[4] = '{2'd1, {128{1'b1}}, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f,
                128'h00000000000000000000000000000001, 128'hf0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0};

    // Reset state.
    #2;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst out_word", out_word, 32'd0);
    chk("rst blk_count", 32'(blk_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst blk_ready", 32'(blk_ready), 32'd1);

    // Table-driven blocks, one at a time with out_ready held high.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].iv_mode, vecs[i].iv_val, vecs[i].pt, vecs[i].ct);
      collect(vecs[i].exp, vecs[i].pt, 1'b1, $sformatf("vec%0d", i));
      exp_cnt++;
      @(negedge clk);
      chk($sformatf("vec%0d idle valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d blk_count", i), 32'(blk_count), 32'(exp_cnt));
    end

    // Reset in the middle of a block.
    send(2'd0, 128'd0, PT1, CT1);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_last", 32'(out_last), 32'd0);
    chk("midrst out_word", out_word, 32'd0);
    chk("midrst blk_count", 32'(blk_count), 32'd0);
    chk("midrst ecb blk_count", 32'(blk_count_e), 32'd0);
    chk("midrst blk_ready", 32'(blk_ready), 32'd1);
    chk("midrst ecb blk_ready", 32'(blk_ready_e), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("postrst valid c%0d", k), 32'(out_valid), 32'd0);
      chk($sformatf("postrst ecb valid c%0d", k), 32'(out_valid_e), 32'd0);
    end
    exp_cnt = 0;
    send(2'd0, 128'd0, PT1, CT1);
    collect(PT1, PT1, 1'b1, "postrst");
    exp_cnt++;
    @(negedge clk);
    chk("postrst blk_count", 32'(blk_count), 32'(exp_cnt));

    // Back-to-back blocks with a five-cycle stall at word 1.
    @(negedge clk);
    iv_load = 1'b1;
    iv      = IV0;
    @(negedge clk);
    iv_load   = 1'b0;
    blk_valid = 1'b1;
    blk_pt    = PT1;
    blk_ct    = CT1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b w0", out_word, 32'h6bc1bee2);
    chk("b2b w0 ready", 32'(blk_ready), 32'd0);
    blk_pt = PT2;
    blk_ct = CT2;
    @(negedge clk);
    chk("b2b w1", out_word, 32'h2e409f96);
    out_ready = 1'b0;
    iv_load   = 1'b1;
    iv        = {128{1'b1}};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall word c%0d", k), out_word, 32'h2e409f96);
      chk($sformatf("stall valid c%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall last c%0d", k), 32'(out_last), 32'd0);
      chk($sformatf("stall blk_ready c%0d", k), 32'(blk_ready), 32'd0);
    end
    out_ready = 1'b1;
    iv_load   = 1'b0;
    @(negedge clk);
    chk("b2b w2", out_word, 32'he93d7e11);
    @(negedge clk);
    chk("b2b w3", out_word, 32'h7393172a);
    chk("b2b w3 last", 32'(out_last), 32'd1);
    chk("b2b w3 ready", 32'(blk_ready), 32'd1);
    @(negedge clk);
    blk_valid = 1'b0;
    exp_cnt++;
    chk("b2b gap valid", 32'(out_valid), 32'd1);
    chk("b2b blk2 w0", out_word, 32'hae2d8a57);
    chk("b2b blk2 last", 32'(out_last), 32'd0);
    chk("b2b count1", 32'(blk_count), 32'(exp_cnt));
    @(negedge clk);
    chk("b2b blk2 w1", out_word, 32'h1e03ac9c);
    @(negedge clk);
    chk("b2b blk2 w2", out_word, 32'h9eb76fac);
    @(negedge clk);
    chk("b2b blk2 w3", out_word, 32'h45af8e51);
    chk("b2b blk2 w3 last", 32'(out_last), 32'd1);
    @(negedge clk);
    exp_cnt++;
    chk("b2b end valid", 32'(out_valid), 32'd0);
    chk("b2b count2", 32'(blk_count), 32'(exp_cnt));

    // Counter wrap on the ECB instance, counter preloaded to 0xFFFF.
    @(negedge clk);
    force dut_ecb.cnt_q = 16'hffff;
    @(negedge clk);
    release dut_ecb.cnt_q;
    @(negedge clk);
    chk("wrap preload", 32'(blk_count_e), 32'h0000ffff);
    send(2'd0, 128'd0, PT2, CT2);
    collect(128'd0, PT2, 1'b0, "wrap");
    exp_cnt++;
    @(negedge clk);
    chk("wrap ecb blk_count", 32'(blk_count_e), 32'd0);
    chk("wrap cbc blk_count", 32'(blk_count), 32'(exp_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
